// File: rtl/object_layer_arbiter.sv
// object_layer_arbiter
// Shares one 8-bit VGA colour output between NUM_LAYERS object drawers.
// Layer 0 has the highest priority; a layer whose pixel is transparent, or
// which is in the dark half of a hit-flash, lets lower layers or the
// background show through. Each layer runs its own hit-flash sequencer,
// paced by startOfFrame.
module object_layer_arbiter #(
    parameter int              NUM_LAYERS        = 4,
    parameter int              BLINK_FRAMES      = 4,
    parameter int              FLASH_HALVES      = 6,
    parameter logic [7:0]      COLOR_TRANSPARENT = 8'hFF,
    localparam int             IDX_W             = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         startOfFrame,
    input  logic [NUM_LAYERS-1:0][7:0]   layerRGB,
    input  logic [NUM_LAYERS-1:0]        hitPulse,
    input  logic [7:0]                   backgroundRGB,
    output logic [7:0]                   RGBOut,
    output logic                         drawValid,
    output logic [IDX_W-1:0]             drawLayerIdx,
    output logic [NUM_LAYERS-1:0]        flashActive
);

    // Counters compare against the last index of each phase, so they never wrap.
    localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] LAST_HALF  = 8'(FLASH_HALVES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLASH_OFF = 2'd1,
        FLASH_ON  = 2'd2
    } layerState_t;

    layerState_t            r_state    [NUM_LAYERS];
    logic [7:0]             r_frameCnt [NUM_LAYERS];
    logic [7:0]             r_halfCnt  [NUM_LAYERS];

    logic [NUM_LAYERS-1:0]  w_visible;
    logic                   w_winFound;
    logic [IDX_W-1:0]       w_winIdx;
    logic [7:0]             w_winRGB;

    // Per-layer flash sequencer: a hit always restarts the flash dark; frames are counted only while flashing.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                r_state[i]    <= IDLE;
                r_frameCnt[i] <= 8'd0;
                r_halfCnt[i]  <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (hitPulse[i]) begin
                    r_state[i]    <= FLASH_OFF;
                    r_frameCnt[i] <= 8'd0;
                    r_halfCnt[i]  <= 8'd0;
                end else if (startOfFrame && (r_state[i] != IDLE)) begin
                    if (r_frameCnt[i] == LAST_FRAME) begin
                        r_frameCnt[i] <= 8'd0;
                        r_halfCnt[i]  <= r_halfCnt[i] + 8'd1;
                        if (r_halfCnt[i] == LAST_HALF) begin
                            r_state[i] <= IDLE;
                        end else if (r_state[i] == FLASH_OFF) begin
                            r_state[i] <= FLASH_ON;
                        end else begin
                            r_state[i] <= FLASH_OFF;
                        end
                    end else begin
                        r_frameCnt[i] <= r_frameCnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    // Decode each layer's state into visibility and flash-in-progress flags.
    always_comb begin
        w_visible   = '0;
        flashActive = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_visible[i]   = (r_state[i] != FLASH_OFF);
            flashActive[i] = (r_state[i] != IDLE);
        end
    end

    // Priority search: scanning from the lowest priority upward lets the lowest drawn index overwrite the rest.
    always_comb begin
        w_winFound = 1'b0;
        w_winIdx   = '0;
        w_winRGB   = backgroundRGB;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (w_visible[i] && (layerRGB[i] != COLOR_TRANSPARENT)) begin
                w_winFound = 1'b1;
                w_winIdx   = IDX_W'(i);
                w_winRGB   = layerRGB[i];
            end
        end
    end

    // Output register: one clock of latency from the drawer colours to the VGA pixel.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            RGBOut       <= 8'h00;
            drawValid    <= 1'b0;
            drawLayerIdx <= '0;
        end else begin
            RGBOut       <= w_winRGB;
            drawValid    <= w_winFound;
            drawLayerIdx <= w_winIdx;
        end
    end

endmodule

// File: tb/tb_object_layer_arbiter.sv
// tb_object_layer_arbiter
// Directed scenarios with literal expectations, followed by random traffic,
// all checked every cycle against a frame-counting model of the flash.
module tb_object_layer_arbiter;

    localparam int         NL     = 4;
    localparam int         BLINK  = 4;
    localparam int         HALVES = 6;
    localparam logic [7:0] TR     = 8'hFF;

    logic                 clk;
    logic                 resetN;
    logic                 startOfFrame;
    logic [NL-1:0][7:0]   layerRGB;
    logic [NL-1:0]        hitPulse;
    logic [7:0]           backgroundRGB;
    logic [7:0]           RGBOut;
    logic                 drawValid;
    logic [1:0]           drawLayerIdx;
    logic [NL-1:0]        flashActive;

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 0;

    // Model: frames seen since the last hit, and whether the flash is still running.
    int         framesSinceHit [NL];
    bit         modelActive    [NL];
    logic [7:0] expRGB   = 8'h00;
    logic       expValid = 1'b0;
    logic [1:0] expIdx   = 2'd0;
    logic [3:0] expFlash = 4'd0;

    object_layer_arbiter #(
        .NUM_LAYERS(NL),
        .BLINK_FRAMES(BLINK),
        .FLASH_HALVES(HALVES),
        .COLOR_TRANSPARENT(TR)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .layerRGB(layerRGB),
        .hitPulse(hitPulse),
        .backgroundRGB(backgroundRGB),
        .RGBOut(RGBOut),
        .drawValid(drawValid),
        .drawLayerIdx(drawLayerIdx),
        .flashActive(flashActive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit modelVisible(int i);
        // Dark during even-numbered half-periods of a running flash.
        return !modelActive[i] || (((framesSinceHit[i] / BLINK) % 2) == 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model update plus the per-cycle comparison against the DUT.
    always @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < NL; i++) begin
                framesSinceHit[i] = 0;
                modelActive[i]    = 0;
            end
            expRGB   = 8'h00;
            expValid = 1'b0;
            expIdx   = 2'd0;
        end else begin
            expRGB   = backgroundRGB;
            expValid = 1'b0;
            expIdx   = 2'd0;
            for (int i = 0; i < NL; i++) begin
                if (!expValid && modelVisible(i) && layerRGB[i] != TR) begin
                    expRGB   = layerRGB[i];
                    expValid = 1'b1;
                    expIdx   = 2'(i);
                end
            end
            for (int i = 0; i < NL; i++) begin
                if (hitPulse[i]) begin
                    framesSinceHit[i] = 0;
                    modelActive[i]    = 1;
                end else if (startOfFrame && modelActive[i]) begin
                    framesSinceHit[i]++;
                    if (framesSinceHit[i] == BLINK * HALVES) modelActive[i] = 0;
                end
            end
        end
        for (int i = 0; i < NL; i++) expFlash[i] = modelActive[i];
        #1;
        if (checkEn) begin
            checkOutput("model.RGBOut", RGBOut, expRGB);
            checkOutput("model.drawValid", drawValid, expValid);
            checkOutput("model.drawLayerIdx", drawLayerIdx, expIdx);
            checkOutput("model.flashActive", flashActive, expFlash);
        end
    end

    // One clock cycle of stimulus; returns just after the edge that consumed it.
    task automatic applyStimulus(input logic sof, input logic [NL-1:0] hits);
        @(negedge clk);
        startOfFrame = sof;
        hitPulse     = hits;
        @(posedge clk);
        #2;
    endtask

    task automatic sendFrames(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, '0);
            applyStimulus(1'b0, '0);
            applyStimulus(1'b0, '0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected end by 1000000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetN        = 1'b0;
        startOfFrame  = 1'b0;
        hitPulse      = '0;
        layerRGB      = {TR, TR, TR, TR};
        backgroundRGB = 8'h25;
        @(posedge clk);
        #2;
        checkEn = 1;
        checkOutput("reset.RGBOut", RGBOut, 8'h00);
        checkOutput("reset.flashActive", flashActive, 4'b0000);
        @(negedge clk);
        resetN = 1'b1;

        // All transparent: background shows.
        applyStimulus(1'b0, '0);
        checkOutput("bg.RGBOut", RGBOut, 8'h25);
        checkOutput("bg.drawValid", drawValid, 1'b0);
        checkOutput("bg.idx", drawLayerIdx, 2'd0);

        // Priority between layers 1 and 2, then layer 0 takes over one cycle later.
        layerRGB = {TR, 8'h1C, 8'hE0, TR};
        applyStimulus(1'b0, '0);
        checkOutput("prio.RGBOut", RGBOut, 8'hE0);
        checkOutput("prio.idx", drawLayerIdx, 2'd1);
        @(negedge clk);
        layerRGB[0] = 8'h03;
        #1;
        checkOutput("latency.RGBOut", RGBOut, 8'hE0);
        @(posedge clk);
        #2;
        checkOutput("layer0.RGBOut", RGBOut, 8'h03);
        checkOutput("layer0.idx", drawLayerIdx, 2'd0);
        layerRGB[0] = TR;

        // Flash on layer 1.
        applyStimulus(1'b0, 4'b0010);
        checkOutput("hit.flashActive", flashActive, 4'b0010);
        applyStimulus(1'b0, '0);
        checkOutput("hit.RGBOut", RGBOut, 8'h1C);
        sendFrames(3);
        checkOutput("f3.RGBOut", RGBOut, 8'h1C);
        sendFrames(1);
        checkOutput("f4.RGBOut", RGBOut, 8'hE0);
        sendFrames(19);
        checkOutput("f23.flashActive", flashActive, 4'b0010);
        sendFrames(1);
        checkOutput("f24.flashActive", flashActive, 4'b0000);
        checkOutput("f24.RGBOut", RGBOut, 8'hE0);

        // Re-hit at frame 10, coinciding with startOfFrame.
        applyStimulus(1'b0, 4'b0010);
        sendFrames(10);
        checkOutput("f10.RGBOut", RGBOut, 8'h1C);
        applyStimulus(1'b1, 4'b0010);
        sendFrames(23);
        checkOutput("rehit23.flashActive", flashActive, 4'b0010);
        sendFrames(1);
        checkOutput("rehit24.flashActive", flashActive, 4'b0000);

        // Independent flashes on layers 0 and 3.
        layerRGB[0] = 8'h03;
        applyStimulus(1'b0, 4'b0001);
        sendFrames(2);
        applyStimulus(1'b0, 4'b1000);
        checkOutput("both.flashActive", flashActive, 4'b1001);
        sendFrames(22);
        checkOutput("l0done.flashActive", flashActive, 4'b1000);
        sendFrames(2);
        checkOutput("l3done.flashActive", flashActive, 4'b0000);

        // Asynchronous reset in the middle of a flash.
        applyStimulus(1'b0, 4'b0010);
        sendFrames(7);
        @(negedge clk);
        #3;
        resetN = 1'b0;
        #1;
        checkOutput("async.RGBOut", RGBOut, 8'h00);
        checkOutput("async.flashActive", flashActive, 4'b0000);
        checkOutput("async.drawValid", drawValid, 1'b0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        sendFrames(8);
        checkOutput("postreset.flashActive", flashActive, 4'b0000);
        checkOutput("postreset.RGBOut", RGBOut, 8'h03);

        // Random traffic, including hits coinciding with frames and short resets.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int i = 0; i < NL; i++)
                layerRGB[i] = ($urandom_range(0, 2) == 0) ? TR : 8'($urandom);
            backgroundRGB = 8'($urandom);
            startOfFrame  = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < NL; i++)
                hitPulse[i] = ($urandom_range(0, 149) == 0);
            resetN = ($urandom_range(0, 499) != 0);
        end
        @(negedge clk);
        resetN       = 1'b1;
        startOfFrame = 1'b0;
        hitPulse     = '0;
        repeat (3) @(posedge clk);
        #3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
